fifo_ctrl_fsm: RTL and testbench

- Control state machine for the switch datapath.
- Consumes the control/config interface (clk, reset, init, per-FIFO low/high thresholds, empties, errors) and drives the system state.
- Holds the threshold values latched during INIT for the main FIFO, VC0, VC1, D0 and D1 FIFOs.
- Reports idle/active status and sticky per-FIFO errors to the rest of the switch.

---
 rtl/fsm_pkg.sv | 28 ++
 rtl/fsm_cfg_regs.sv | 44 ++++
 rtl/fifo_ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_fifo_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared constants for the switch control FSM: one-hot state encodings,
// FIFO index map and the position of the sticky config-error bit.
package fsm_pkg;

    localparam int NUM_FIFOS   = 5;
    localparam int CFG_ERR_BIT = NUM_FIFOS;

    localparam int MAIN = 0;
    localparam int VC0  = 1;
    localparam int VC1  = 2;
    localparam int D0   = 3;
    localparam int D1   = 4;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    typedef enum logic [4:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

endpackage

// File: rtl/fsm_cfg_regs.sv
// Threshold register bank: one low/high pair per FIFO, loaded while enabled,
// plus the low<high validity check on the values about to be captured.
module fsm_cfg_regs import fsm_pkg::*; #(
    parameter int TW = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NUM_FIFOS-1:0][TW-1:0]  low_in,
    input  logic [NUM_FIFOS-1:0][TW-1:0]  high_in,
    output logic [NUM_FIFOS-1:0][TW-1:0]  low_out,
    output logic [NUM_FIFOS-1:0][TW-1:0]  high_out,
    output logic                          cfg_ok
);

    logic [NUM_FIFOS-1:0][TW-1:0] low_q, low_d;
    logic [NUM_FIFOS-1:0][TW-1:0] high_q, high_d;

    // cfg_ok looks at the inputs, since those are what the exit edge captures.
    always_comb begin
        low_d  = load ? low_in  : low_q;
        high_d = load ? high_in : high_q;
        cfg_ok = 1'b1;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (low_in[i] >= high_in[i]) begin
                cfg_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_q  <= '0;
            high_q <= '0;
        end else begin
            low_q  <= low_d;
            high_q <= high_d;
        end
    end

    assign low_out  = low_q;
    assign high_out = high_q;

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Switch control FSM: sequences RESET/INIT/IDLE/ACTIVE/ERROR, latches FIFO
// thresholds during INIT and keeps sticky per-FIFO and config error flags.
module fifo_ctrl_fsm import fsm_pkg::*; #(
    parameter int TW = 5,
    parameter int NF = NUM_FIFOS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [TW-1:0] main_fifo_low,
    input  logic [TW-1:0] main_fifo_high,
    input  logic [TW-1:0] Vco_low,
    input  logic [TW-1:0] Vco_high,
    input  logic [TW-1:0] Vc1_low,
    input  logic [TW-1:0] Vc1_high,
    input  logic [TW-1:0] Do_low,
    input  logic [TW-1:0] Do_high,
    input  logic [TW-1:0] D1_low,
    input  logic [TW-1:0] D1_high,
    input  logic [NF-1:0] empties,
    input  logic [NF-1:0] errors,
    output logic [4:0]    state,
    output logic          idle_out,
    output logic          active_out,
    output logic [NF:0]   error_out,
    output logic [TW-1:0] main_fifo_low_out,
    output logic [TW-1:0] main_fifo_high_out,
    output logic [TW-1:0] Vco_low_out,
    output logic [TW-1:0] Vco_high_out,
    output logic [TW-1:0] Vc1_low_out,
    output logic [TW-1:0] Vc1_high_out,
    output logic [TW-1:0] Do_low_out,
    output logic [TW-1:0] Do_high_out,
    output logic [TW-1:0] D1_low_out,
    output logic [TW-1:0] D1_high_out
);

    state_e                       state_q, state_d;
    logic [NF:0]                  err_q, err_d;
    logic                         idle_q, active_q;
    logic                         cfg_load, cfg_ok;
    logic [NUM_FIFOS-1:0][TW-1:0] low_in, high_in, low_out, high_out;

    assign low_in  = {D1_low,  Do_low,  Vc1_low,  Vco_low,  main_fifo_low};
    assign high_in = {D1_high, Do_high, Vc1_high, Vco_high, main_fifo_high};

    fsm_cfg_regs #(.TW(TW)) u_cfg_regs (
        .clk      (clk),
        .reset    (reset),
        .load     (cfg_load),
        .low_in   (low_in),
        .high_in  (high_in),
        .low_out  (low_out),
        .high_out (high_out),
        .cfg_ok   (cfg_ok)
    );

    // No handshake: init is a level request, errors are single-cycle pulses
    // sampled on every edge, and empties is a level status vector.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cfg_load = 1'b0;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                cfg_load         = 1'b1;
                err_d[NF-1:0]    = err_q[NF-1:0] | errors;
                if (|errors) begin
                    state_d = S_ERROR;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (cfg_ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_ERROR;
                    err_d[NF] = 1'b1;
                end
            end
            S_IDLE, S_ACTIVE: begin
                err_d[NF-1:0] = err_q[NF-1:0] | errors;
                if (|errors) begin
                    state_d = S_ERROR;
                end else if (init) begin
                    state_d = S_INIT;
                end else if (empties == {NF{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_ERROR: err_d[NF-1:0] = err_q[NF-1:0] | errors;
            default: state_d = S_RESET;
        endcase
    end

    // Flags are registered from state_d so they are exact decodes of state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RESET;
            err_q    <= '0;
            idle_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            idle_q   <= (state_d == S_IDLE);
            active_q <= (state_d == S_ACTIVE);
        end
    end

    assign state      = state_q;
    assign idle_out   = idle_q;
    assign active_out = active_q;
    assign error_out  = err_q;

    assign main_fifo_low_out  = low_out[MAIN];
    assign main_fifo_high_out = high_out[MAIN];
    assign Vco_low_out        = low_out[VC0];
    assign Vco_high_out       = high_out[VC0];
    assign Vc1_low_out        = low_out[VC1];
    assign Vc1_high_out       = high_out[VC1];
    assign Do_low_out         = low_out[D0];
    assign Do_high_out        = high_out[D0];
    assign D1_low_out         = low_out[D1];
    assign D1_high_out        = high_out[D1];

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Scoreboard bench for fifo_ctrl_fsm: a driver pushes reference-model
// expectations per cycle, a monitor pops and compares after each rising edge.
module tb_fifo_ctrl_fsm;
    import fsm_pkg::*;

    localparam int TW = 5;
    localparam int NF = 5;
    localparam int W  = 5 + 2 + (NF + 1) + 10 * TW;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          init = 1'b0;
    logic [NF-1:0] empties = '1;
    logic [NF-1:0] errors = '0;
    logic [TW-1:0] lo_in[5], hi_in[5], nxt_lo[5], nxt_hi[5];
    logic [4:0]    state;
    logic          idle_out, active_out;
    logic [NF:0]   error_out;
    logic [TW-1:0] lo_out[5], hi_out[5];

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    int            m_st;
    logic [NF:0]   m_err;
    logic [TW-1:0] m_lo[5], m_hi[5];

    always #5 clk = ~clk;

    fifo_ctrl_fsm #(.TW(TW), .NF(NF)) dut (
        .clk                (clk),
        .reset              (reset),
        .init               (init),
        .main_fifo_low      (lo_in[MAIN]),
        .main_fifo_high     (hi_in[MAIN]),
        .Vco_low            (lo_in[VC0]),
        .Vco_high           (hi_in[VC0]),
        .Vc1_low            (lo_in[VC1]),
        .Vc1_high           (hi_in[VC1]),
        .Do_low             (lo_in[D0]),
        .Do_high            (hi_in[D0]),
        .D1_low             (lo_in[D1]),
        .D1_high            (hi_in[D1]),
        .empties            (empties),
        .errors             (errors),
        .state              (state),
        .idle_out           (idle_out),
        .active_out         (active_out),
        .error_out          (error_out),
        .main_fifo_low_out  (lo_out[MAIN]),
        .main_fifo_high_out (hi_out[MAIN]),
        .Vco_low_out        (lo_out[VC0]),
        .Vco_high_out       (hi_out[VC0]),
        .Vc1_low_out        (lo_out[VC1]),
        .Vc1_high_out       (hi_out[VC1]),
        .Do_low_out         (lo_out[D0]),
        .Do_high_out        (hi_out[D0]),
        .D1_low_out         (lo_out[D1]),
        .D1_high_out        (hi_out[D1])
    );

    function automatic logic [W-1:0] pack(input logic [4:0] st, input logic idl, input logic act,
                                          input logic [NF:0] er, input logic [TW-1:0] lo[5],
                                          input logic [TW-1:0] hi[5]);
        logic [10*TW-1:0] th;
        th = '0;
        for (int i = 0; i < 5; i++) begin
            th[i*2*TW +: TW]      = lo[i];
            th[i*2*TW + TW +: TW] = hi[i];
        end
        return {st, idl, act, er, th};
    endfunction

    function automatic logic [W-1:0] pack_dut();
        return pack(state, idle_out, active_out, error_out, lo_out, hi_out);
    endfunction

    function automatic logic [W-1:0] model_vec();
        return pack(5'(1 << m_st), m_st == M_IDLE, m_st == M_ACTIVE, m_err, m_lo, m_hi);
    endfunction

    task automatic model_reset();
        m_st  = M_RESET;
        m_err = '0;
        for (int i = 0; i < 5; i++) begin
            m_lo[i] = '0;
            m_hi[i] = '0;
        end
    endtask

    // One rising edge of the reference: errors beat init beat activity.
    task automatic model_step(input logic i_init, input logic [NF-1:0] i_emp,
                              input logic [NF-1:0] i_err);
        bit cfg_bad;
        cfg_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (lo_in[i] >= hi_in[i]) cfg_bad = 1'b1;
        end
        if (m_st != M_RESET) m_err[NF-1:0] = m_err[NF-1:0] | i_err;
        case (m_st)
            M_RESET: m_st = M_INIT;
            M_INIT: begin
                for (int i = 0; i < 5; i++) begin
                    m_lo[i] = lo_in[i];
                    m_hi[i] = hi_in[i];
                end
                if (i_err != 0) m_st = M_ERROR;
                else if (i_init) m_st = M_INIT;
                else if (cfg_bad) begin
                    m_st = M_ERROR;
                    m_err[CFG_ERR_BIT] = 1'b1;
                end else m_st = M_IDLE;
            end
            M_IDLE, M_ACTIVE: begin
                if (i_err != 0) m_st = M_ERROR;
                else if (i_init) m_st = M_INIT;
                else m_st = (i_emp == '1) ? M_IDLE : M_ACTIVE;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] e);
        chk({tag, "_state_flags"}, W'(a[W-1 -: 7]), W'(e[W-1 -: 7]));
        chk({tag, "_errors"}, W'(a[W-8 -: NF+1]), W'(e[W-8 -: NF+1]));
        chk({tag, "_thresholds"}, W'(a[10*TW-1:0]), W'(e[10*TW-1:0]));
    endtask

    task automatic set_all(input int lo, input int hi);
        for (int i = 0; i < 5; i++) begin
            nxt_lo[i] = TW'(lo);
            nxt_hi[i] = TW'(hi);
        end
    endtask

    // rst_mode: 0 = none, 1 = reset held across the edge, 2 = pulse between edges
    task automatic drive_cycle(input logic i_init, input logic [NF-1:0] i_emp,
                               input logic [NF-1:0] i_err, input int rst_mode);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            lo_in[i] = nxt_lo[i];
            hi_in[i] = nxt_hi[i];
        end
        init    = i_init;
        empties = i_emp;
        errors  = i_err;
        if (rst_mode == 1) begin
            reset = 1'b1;
            model_reset();
        end else begin
            if (rst_mode == 2) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk_vec("async_reset", pack_dut(), model_vec());
                #1;
            end
            reset = 1'b0;
            model_step(i_init, i_emp, i_err);
        end
        exp_q.push_back(model_vec());
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_vec("cycle", pack_dut(), e);
            end
        end
    end

    initial begin : driver
        int r, lo, mode;
        logic ri;
        logic [NF-1:0] re, rem;
        reset = 1'b0;
        set_all(1, 4);
        for (int i = 0; i < 5; i++) begin
            lo_in[i] = nxt_lo[i];
            hi_in[i] = nxt_hi[i];
        end
        model_reset();
        #1 reset = 1'b1;
        #1 chk_vec("power_on_reset", pack_dut(), model_vec());

        // Reset walk: RESET -> INIT -> IDLE
        drive_cycle(1'b0, '1, '0, 1);
        drive_cycle(1'b0, '1, '0, 0);
        drive_cycle(1'b0, '1, '0, 0);
        drive_cycle(1'b0, '1, '0, 0);

        // Config capture through a 3-cycle init, then inputs change in IDLE
        nxt_lo[VC0] = 5'd2;
        nxt_hi[VC0] = 5'd7;
        drive_cycle(1'b1, '1, '0, 0);
        drive_cycle(1'b1, '1, '0, 0);
        drive_cycle(1'b1, '1, '0, 0);
        drive_cycle(1'b0, '1, '0, 0);
        nxt_lo[VC0] = 5'd9;
        nxt_hi[VC0] = 5'd3;
        drive_cycle(1'b0, '1, '0, 0);
        drive_cycle(1'b0, '1, '0, 0);
        nxt_lo[VC0] = 5'd2;
        nxt_hi[VC0] = 5'd7;

        // Activity in and out of ACTIVE
        drive_cycle(1'b0, 5'b11110, '0, 0);
        drive_cycle(1'b0, 5'b11111, '0, 0);
        drive_cycle(1'b0, 5'b01111, '0, 0);
        drive_cycle(1'b0, 5'b01111, '0, 0);

        // errors and init together, then a later pulse accumulates
        drive_cycle(1'b1, 5'b01111, 5'b00100, 0);
        drive_cycle(1'b0, '1, '0, 0);
        drive_cycle(1'b0, '1, 5'b00001, 0);
        drive_cycle(1'b1, 5'b00000, '0, 0);

        // Async pulse out of ERROR, then a low==high config
        nxt_lo[MAIN] = 5'd6;
        nxt_hi[MAIN] = 5'd6;
        drive_cycle(1'b0, '1, '0, 2);
        drive_cycle(1'b0, '1, '0, 0);
        drive_cycle(1'b1, '1, '0, 0);
        drive_cycle(1'b0, 5'b00011, '0, 0);
        drive_cycle(1'b1, '1, '0, 0);
        set_all(1, 4);
        drive_cycle(1'b0, '1, '0, 1);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            mode = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
            if (m_st == M_ERROR && $urandom_range(0, 9) == 0) mode = 2;
            ri  = ($urandom_range(0, 7) == 0);
            re  = ($urandom_range(0, 29) == 0) ? (NF'(1) << $urandom_range(0, NF-1)) : '0;
            rem = ($urandom_range(0, 1) == 1) ? '1 : NF'($urandom);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    lo = $urandom_range(0, 30);
                    nxt_lo[i] = TW'(lo);
                    if ($urandom_range(0, 19) == 0) nxt_hi[i] = TW'($urandom_range(0, lo));
                    else nxt_hi[i] = TW'($urandom_range(lo + 1, 31));
                end
            end
            drive_cycle(ri, rem, re, mode);
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
